// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Forward-select encodings and the scoreboard entry layout live here.
package hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXMEM   = 2'd1;
  localparam logic [1:0] FWD_MEMWB   = 2'd2;
  localparam logic [1:0] FWD_WB      = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] num;
    logic       load;
  } sbEntry_t;

  // Slot 0 holds the producer now entering EX, so its value sits in EX/MEM next cycle.
  function automatic logic [1:0] fwdSelect(input logic anyHit, input logic [1:0] youngest,
                                           input logic wbBypass);
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (anyHit) begin
      case (youngest)
        2'd0:    sel = FWD_EXMEM;
        2'd1:    sel = FWD_MEMWB;
        default: sel = wbBypass ? FWD_REGFILE : FWD_WB;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// Compares one decode read-register number against every scoreboard slot.
// Reports the per-slot hit vector, the youngest (lowest-index) hit and a load-use hit on slot 0.
module hazard_slot_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic [4:0]            i_readNum,
  input  sbEntry_t [DEPTH-1:0]  i_slots,
  output logic [DEPTH-1:0]      o_hit,
  output logic [1:0]            o_youngest,
  output logic                  o_loadHit
);

  logic [DEPTH-1:0] w_hit;

  // Register 0 is hard-wired, so it never creates a dependency.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_hit[k] = (i_readNum != 5'd0) && i_slots[k].valid && (i_slots[k].num == i_readNum);
    end
  end

  always_comb begin
    o_youngest = 2'd0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_hit[k]) o_youngest = 2'(k);
    end
  end

  assign o_hit     = w_hit;
  assign o_loadHit = w_hit[0] && i_slots[0].load;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: a shift-register scoreboard of in-flight writes driving decode stall.
// Define HAZARD_FORWARD_EN for load-use-only stalls plus registered forward selects (DEPTH must be 3).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  reg_read1_num_realtime,
  input  logic [4:0]  reg_read2_num_realtime,
  input  logic        id_write_en,
  input  logic [4:0]  id_write_num,
  input  logic        id_is_load,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  fwd1_sel,
  output logic [1:0]  fwd2_sel,
  output logic [31:0] stall_count
);

  sbEntry_t [DEPTH-1:0] r_slots;
  sbEntry_t             w_issue;
  logic [DEPTH-1:0]     w_hit1;
  logic [DEPTH-1:0]     w_hit2;
  logic [1:0]           w_young1;
  logic [1:0]           w_young2;
  logic                 w_loadHit1;
  logic                 w_loadHit2;
  logic                 w_stall;
  logic [31:0]          r_stallCount;

  hazard_slot_match #(.DEPTH(DEPTH)) u_match1 (
    .i_readNum  (reg_read1_num_realtime),
    .i_slots    (r_slots),
    .o_hit      (w_hit1),
    .o_youngest (w_young1),
    .o_loadHit  (w_loadHit1)
  );

  hazard_slot_match #(.DEPTH(DEPTH)) u_match2 (
    .i_readNum  (reg_read2_num_realtime),
    .i_slots    (r_slots),
    .o_hit      (w_hit2),
    .o_youngest (w_young2),
    .o_loadHit  (w_loadHit2)
  );

`ifdef HAZARD_FORWARD_EN
  logic [1:0] r_fwd1Sel;
  logic [1:0] r_fwd2Sel;

  assign w_stall = !flush && (w_loadHit1 || w_loadHit2);

  // Selects latch alongside decode's pipeline register, so a bubble carries select 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_fwd1Sel <= FWD_REGFILE;
      r_fwd2Sel <= FWD_REGFILE;
    end else if (w_stall || flush) begin
      r_fwd1Sel <= FWD_REGFILE;
      r_fwd2Sel <= FWD_REGFILE;
    end else begin
      r_fwd1Sel <= fwdSelect(|w_hit1, w_young1, WB_BYPASS);
      r_fwd2Sel <= fwdSelect(|w_hit2, w_young2, WB_BYPASS);
    end
  end

  assign fwd1_sel = r_fwd1Sel;
  assign fwd2_sel = r_fwd2Sel;
`else
  localparam logic [DEPTH-1:0] HAZARD_MASK =
    WB_BYPASS ? {1'b0, {(DEPTH-1){1'b1}}} : {DEPTH{1'b1}};

  logic w_unused;

  assign w_stall  = !flush && ((|(w_hit1 & HAZARD_MASK)) || (|(w_hit2 & HAZARD_MASK)));
  assign fwd1_sel = FWD_REGFILE;
  assign fwd2_sel = FWD_REGFILE;
  assign w_unused = ^{w_young1, w_young2, w_loadHit1, w_loadHit2};
`endif

  // A stalled or squashed decode instruction enters the pipe as a bubble.
  always_comb begin
    w_issue       = '0;
    w_issue.valid = id_write_en && (id_write_num != 5'd0) && !w_stall && !flush;
    w_issue.num   = id_write_num;
    w_issue.load  = id_is_load;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_slots      <= '0;
      r_stallCount <= '0;
    end else begin
      r_slots[0] <= w_issue;
      for (int k = 1; k < DEPTH; k++) begin
        r_slots[k] <= r_slots[k-1];
      end
      if (w_stall && (r_stallCount != 32'hFFFF_FFFF)) begin
        r_stallCount <= r_stallCount + 32'd1;
      end
    end
  end

  assign stall       = w_stall;
  assign stall_count = r_stallCount;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed vector table plus randomized traffic
// against a list-of-in-flight-writes reference model. Honors HAZARD_FORWARD_EN.
module tb_hazard_scoreboard;

  localparam int DEPTH     = 3;
  localparam bit WB_BYPASS = 1'b0;

  logic        clk;
  logic        clr;
  logic [4:0]  rd1;
  logic [4:0]  rd2;
  logic        weIn;
  logic [4:0]  wnIn;
  logic        ldIn;
  logic        flushIn;
  logic        stall;
  logic [1:0]  fwd1_sel;
  logic [1:0]  fwd2_sel;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.DEPTH(DEPTH), .WB_BYPASS(WB_BYPASS)) dut (
    .clk                    (clk),
    .clr                    (clr),
    .reg_read1_num_realtime (rd1),
    .reg_read2_num_realtime (rd2),
    .id_write_en            (weIn),
    .id_write_num           (wnIn),
    .id_is_load             (ldIn),
    .flush                  (flushIn),
    .stall                  (stall),
    .fwd1_sel               (fwd1_sel),
    .fwd2_sel               (fwd2_sel),
    .stall_count            (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each in-flight write remembers how many cycles old it is.
  typedef struct {
    int num;
    bit load;
    int age;
  } flight_t;

  flight_t     inFlight[$];
  logic [31:0] mCount;
  logic [1:0]  mF1;
  logic [1:0]  mF2;

  typedef struct {
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        we;
    logic [4:0]  wn;
    logic        ld;
    logic        fl;
    logic        cl;
    logic        expStall;
    logic [1:0]  expF1;
    logic [1:0]  expF2;
    logic [31:0] expCount;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                                 input logic [4:0] wn, input logic ld, input logic fl,
                                 input logic cl, input logic es, input logic [1:0] f1,
                                 input logic [1:0] f2, input logic [31:0] cnt);
    vec_t v;
    v = '{r1, r2, we, wn, ld, fl, cl, es, f1, f2, cnt};
    vecs.push_back(v);
  endfunction

  function automatic int youngestMatch(input logic [4:0] r);
    int best;
    best = -1;
    if (r == 5'd0) return -1;
    foreach (inFlight[i]) begin
      if (inFlight[i].num == int'(r) && (best < 0 || inFlight[i].age < inFlight[best].age))
        best = i;
    end
    return best;
  endfunction

  function automatic logic portHazard(input logic [4:0] r);
    int i;
    i = youngestMatch(r);
    if (i < 0) return 1'b0;
`ifdef HAZARD_FORWARD_EN
    return (inFlight[i].age == 0) && inFlight[i].load;
`else
    return (inFlight[i].age < DEPTH - 1) || !WB_BYPASS;
`endif
  endfunction

  function automatic logic [1:0] portFwd(input logic [4:0] r);
`ifdef HAZARD_FORWARD_EN
    int i;
    i = youngestMatch(r);
    if (i < 0) return 2'd0;
    if (inFlight[i].age == 0) return 2'd1;
    if (inFlight[i].age == 1) return 2'd2;
    return WB_BYPASS ? 2'd0 : 2'd3;
`else
    if (r == 5'd31) return 2'd0;
    return 2'd0;
`endif
  endfunction

  function automatic logic modelStall(input logic [4:0] r1, input logic [4:0] r2, input logic fl);
    return !fl && (portHazard(r1) || portHazard(r2));
  endfunction

  function automatic void modelReset();
    inFlight.delete();
    mCount = 32'd0;
    mF1    = 2'd0;
    mF2    = 2'd0;
  endfunction

  function automatic void modelAdvance(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                                       input logic [4:0] wn, input logic ld, input logic fl,
                                       input logic cl, input logic st);
    flight_t f;
    if (cl) begin
      modelReset();
      return;
    end
    if (st && mCount != 32'hFFFF_FFFF) mCount = mCount + 32'd1;
    mF1 = (st || fl) ? 2'd0 : portFwd(r1);
    mF2 = (st || fl) ? 2'd0 : portFwd(r2);
    foreach (inFlight[i]) inFlight[i].age++;
    for (int i = inFlight.size() - 1; i >= 0; i--) begin
      if (inFlight[i].age >= DEPTH) inFlight.delete(i);
    end
    if (we && wn != 5'd0 && !st && !fl) begin
      f = '{int'(wn), ld, 0};
      inFlight.push_back(f);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Entered just after a negedge; returns at the next negedge with stall as sampled mid-cycle.
  task automatic applyStimulus(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                               input logic [4:0] wn, input logic ld, input logic fl,
                               input logic cl, output logic sawStall);
    logic expSt;
    rd1 = r1; rd2 = r2; weIn = we; wnIn = wn; ldIn = ld; flushIn = fl; clr = cl;
    #1;
    expSt    = modelStall(r1, r2, fl);
    sawStall = stall;
    checkOutput("model_stall", {31'd0, stall}, {31'd0, expSt});
    @(posedge clk);
    modelAdvance(r1, r2, we, wn, ld, fl, cl, expSt);
    #1;
    checkOutput("model_fwd1", {30'd0, fwd1_sel}, {30'd0, mF1});
    checkOutput("model_fwd2", {30'd0, fwd2_sel}, {30'd0, mF2});
    checkOutput("model_count", stall_count, mCount);
    @(negedge clk);
  endtask

  initial begin
    logic s;
    clr = 1'b1; rd1 = '0; rd2 = '0; weIn = 1'b0; wnIn = '0; ldIn = 1'b0; flushIn = 1'b0;
    modelReset();

    for (int i = 0; i < 10; i++) addVec(5'd8, 5'd9, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 32'd0);
`ifdef HAZARD_FORWARD_EN
    addVec(5'd0, 5'd0, 1, 5'd5, 1, 0, 0, 0, 2'd0, 2'd0, 32'd0);
    addVec(5'd5, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'd0, 2'd0, 32'd1);
    addVec(5'd5, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd2, 2'd0, 32'd1);
    addVec(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 32'd1);
    addVec(5'd0, 5'd0, 1, 5'd5, 0, 0, 0, 0, 2'd0, 2'd0, 32'd1);
    addVec(5'd0, 5'd5, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd1, 32'd1);
    addVec(5'd0, 5'd5, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd2, 32'd1);
    addVec(5'd5, 5'd5, 0, 5'd0, 0, 0, 0, 0, 2'd3, 2'd3, 32'd1);
    addVec(5'd0, 5'd0, 1, 5'd7, 0, 0, 0, 0, 2'd0, 2'd0, 32'd1);
    addVec(5'd7, 5'd0, 0, 5'd0, 0, 1, 0, 0, 2'd0, 2'd0, 32'd1);
    addVec(5'd7, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd2, 2'd0, 32'd1);
    addVec(5'd0, 5'd0, 1, 5'd3, 1, 0, 0, 0, 2'd0, 2'd0, 32'd1);
    addVec(5'd3, 5'd0, 0, 5'd0, 0, 0, 1, 1, 2'd0, 2'd0, 32'd0);
    addVec(5'd3, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 32'd0);
    addVec(5'd4, 5'd0, 1, 5'd4, 1, 0, 0, 0, 2'd0, 2'd0, 32'd0);
    addVec(5'd4, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'd0, 2'd0, 32'd1);
    addVec(5'd4, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd2, 2'd0, 32'd1);
`else
    addVec(5'd0, 5'd0, 1, 5'd8, 0, 0, 0, 0, 2'd0, 2'd0, 32'd0);
    addVec(5'd8, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'd0, 2'd0, 32'd1);
    addVec(5'd8, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'd0, 2'd0, 32'd2);
    addVec(5'd0, 5'd8, 0, 5'd0, 0, 0, 0, 1, 2'd0, 2'd0, 32'd3);
    addVec(5'd8, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 32'd3);
    addVec(5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 32'd3);
    addVec(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 32'd3);
    addVec(5'd0, 5'd0, 1, 5'd7, 0, 0, 0, 0, 2'd0, 2'd0, 32'd3);
    addVec(5'd7, 5'd0, 0, 5'd0, 0, 1, 0, 0, 2'd0, 2'd0, 32'd3);
    addVec(5'd7, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'd0, 2'd0, 32'd4);
    addVec(5'd0, 5'd7, 0, 5'd0, 0, 0, 0, 1, 2'd0, 2'd0, 32'd5);
    addVec(5'd7, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 32'd5);
    addVec(5'd0, 5'd0, 1, 5'd3, 0, 0, 0, 0, 2'd0, 2'd0, 32'd5);
    addVec(5'd3, 5'd0, 0, 5'd0, 0, 0, 1, 1, 2'd0, 2'd0, 32'd0);
    addVec(5'd3, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 32'd0);
    addVec(5'd4, 5'd0, 1, 5'd4, 0, 0, 0, 0, 2'd0, 2'd0, 32'd0);
    addVec(5'd4, 5'd0, 0, 5'd0, 0, 0, 0, 1, 2'd0, 2'd0, 32'd1);
    addVec(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0, 32'd1);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    #1;
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    checkOutput("reset_fwd1", {30'd0, fwd1_sel}, 32'd0);
    checkOutput("reset_fwd2", {30'd0, fwd2_sel}, 32'd0);
    checkOutput("reset_count", stall_count, 32'd0);
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r1, vecs[i].r2, vecs[i].we, vecs[i].wn, vecs[i].ld,
                    vecs[i].fl, vecs[i].cl, s);
      checkOutput($sformatf("vec%0d_stall", i), {31'd0, s}, {31'd0, vecs[i].expStall});
      checkOutput($sformatf("vec%0d_fwd1", i), {30'd0, fwd1_sel}, {30'd0, vecs[i].expF1});
      checkOutput($sformatf("vec%0d_fwd2", i), {30'd0, fwd2_sel}, {30'd0, vecs[i].expF2});
      checkOutput($sformatf("vec%0d_count", i), stall_count, vecs[i].expCount);
    end

    // Small register range keeps dependencies frequent.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom % 4 != 0), 5'($urandom_range(0, 7)),
                    1'($urandom % 3 == 0), 1'($urandom % 8 == 0),
                    1'($urandom % 64 == 0), s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
